// File: rtl/timer_bank_pkg.sv
// -----------------------------------------------------------------------------
// timer_bank_pkg
//   Shared register-map constants, CTRL bit positions, the device slot index
//   and the ICB word-address decoder used by timer_bank and its channels.
// -----------------------------------------------------------------------------
package timer_bank_pkg;

    // Global register word offsets.
    localparam logic [7:0] ADR_PSC      = 8'h00;
    localparam logic [7:0] ADR_INT_EN   = 8'h01;
    localparam logic [7:0] ADR_INT_PEND = 8'h02;
    localparam logic [7:0] ADR_INFO     = 8'h03;

    // Channel n occupies words ADR_CH_BASE + CH_STRIDE*n .. +3.
    localparam logic [7:0] ADR_CH_BASE  = 8'h04;
    localparam int         CH_STRIDE    = 4;

    // CTRL register bit positions.
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;

    // Slot index of this device in the peripheral-region decoder (1 KB slots).
    localparam int TIMER_BANK_SLOT = 6;

    // Word offset inside a channel's four-word window.
    typedef enum logic [1:0] {
        CH_CTRL  = 2'd0,
        CH_LOAD  = 2'd1,
        CH_COUNT = 2'd2,
        CH_RSVD  = 2'd3
    } ch_reg_e;

    // Which register an ICB word address selects.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PSC,
        SEL_INT_EN,
        SEL_INT_PEND,
        SEL_INFO,
        SEL_CHAN
    } sel_e;

    typedef struct packed {
        sel_e       sel;
        logic [5:0] ch;
        ch_reg_e    creg;
    } adr_dec_t;

    // Reserved words and channels at or above nch decode to SEL_NONE, so
    // reads of them return 0 and writes to them are dropped.
    function automatic adr_dec_t decode_adr(input logic [7:0] adr, input int nch);
        adr_dec_t   d;
        logic [7:0] off;
        d.sel  = SEL_NONE;
        d.ch   = '0;
        d.creg = CH_RSVD;
        off    = adr - ADR_CH_BASE;
        case (adr)
            ADR_PSC:      d.sel = SEL_PSC;
            ADR_INT_EN:   d.sel = SEL_INT_EN;
            ADR_INT_PEND: d.sel = SEL_INT_PEND;
            ADR_INFO:     d.sel = SEL_INFO;
            default: begin
                d.ch   = off[7:2];
                d.creg = ch_reg_e'(off[1:0]);
                if ((int'(off[7:2]) < nch) && (off[1:0] != 2'd3)) begin
                    d.sel = SEL_CHAN;
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// -----------------------------------------------------------------------------
// timer_bank_if
//   ICB slave bus: independent one-cycle write and read strobes, each answered
//   by a one-cycle acknowledge the cycle after the request.
//   icb_wr/icb_wadr/icb_wdat : write request (word address, data)
//   icb_wack                 : write acknowledge
//   icb_rd/icb_radr          : read request (word address)
//   icb_rdat/icb_rack        : read data and acknowledge (data 0 otherwise)
// -----------------------------------------------------------------------------
interface timer_bank_if;
    logic        icb_wr;
    logic [7:0]  icb_wadr;
    logic [31:0] icb_wdat;
    logic        icb_wack;
    logic        icb_rd;
    logic [7:0]  icb_radr;
    logic [31:0] icb_rdat;
    logic        icb_rack;

    modport master (
        output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
        input  icb_wack, icb_rdat, icb_rack
    );

    modport slave (
        input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
        output icb_wack, icb_rdat, icb_rack
    );
endinterface

// File: rtl/timer_bank_chan.sv
// -----------------------------------------------------------------------------
// timer_bank_chan
//   One down-counting timer channel: CTRL (EN, PERIODIC), LOAD and COUNT.
//   clk, rst           : clock, asynchronous active-low reset
//   tick_i             : shared prescaler tick
//   we_ctrl_i/we_load_i/we_count_i : decoded register write strobes
//   wdat_i             : write data
//   en_o, periodic_o, load_o, count_o : register values for readback
//   expire_o           : one-cycle pulse when a tick finds COUNT at 0
// -----------------------------------------------------------------------------
module timer_bank_chan
    import timer_bank_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          we_ctrl_i,
    input  logic          we_load_i,
    input  logic          we_count_i,
    input  logic [31:0]   wdat_i,
    output logic          en_o,
    output logic          periodic_o,
    output logic [CW-1:0] load_o,
    output logic [CW-1:0] count_o,
    output logic          expire_o
);

    logic          en_q, en_d;
    logic          per_q, per_d;
    logic [CW-1:0] load_q, load_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        en_d     = en_q;
        per_d    = per_q;
        load_d   = load_q;
        count_d  = count_q;
        expire_o = 1'b0;

        // Tick-driven counting; lowest priority of all updates.
        if (tick_i && en_q) begin
            if (count_q != '0) begin
                count_d = count_q - CW'(1);
            end else begin
                expire_o = 1'b1;
                if (per_q) begin
                    count_d = load_q;
                end else begin
                    en_d    = 1'b0;
                    count_d = '0;
                end
            end
        end

        // LOAD only reaches COUNT at the next reload or enable.
        if (we_load_i) begin
            load_d = wdat_i[CW-1:0];
        end

        if (we_ctrl_i) begin
            en_d  = wdat_i[CTRL_EN];
            per_d = wdat_i[CTRL_PERIODIC];
            if (!wdat_i[CTRL_EN]) begin
                count_d = count_q;              // disabling freezes COUNT
            end else if (!en_q) begin
                count_d = load_q;               // rising EN: start a fresh period
            end
        end

        // Software COUNT write wins over anything the tick did.
        if (we_count_i) begin
            count_d = wdat_i[CW-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            per_q   <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
        end else begin
            en_q    <= en_d;
            per_q   <= per_d;
            load_q  <= load_d;
            count_q <= count_d;
        end
    end

    assign en_o       = en_q;
    assign periodic_o = per_q;
    assign load_o     = load_q;
    assign count_o    = count_q;

endmodule

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   NCH-channel down-counting timer array with a shared prescaler, per-channel
//   one-shot/periodic mode and masked write-1-to-clear interrupts.
//   clk, rst       : clock, asynchronous active-low reset
//   bus            : ICB slave port (timer_bank_if.slave)
//   timer_int_vec  : per-channel interrupt, INT_PEND & INT_EN
//   timer_int      : OR of timer_int_vec
// -----------------------------------------------------------------------------
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int PW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    timer_bank_if.slave    bus,
    output logic [NCH-1:0] timer_int_vec,
    output logic           timer_int
);

    localparam logic [31:0] INFO_VAL = {8'h00, 8'(PW), 8'(CW), 8'(NCH)};

    adr_dec_t wdec, rdec;

    logic [PW-1:0]  psc_q, psc_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           tick;
    logic [NCH-1:0] inten_q, inten_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic           wack_q;
    logic           rack_q;
    logic [31:0]    rdat_q, rdat_mux;

    logic [NCH-1:0] we_ctrl, we_load, we_count;
    logic [NCH-1:0] en_vec, per_vec, expire_vec;
    logic [CW-1:0]  load_arr  [NCH];
    logic [CW-1:0]  count_arr [NCH];

    logic wr_psc, wr_inten, wr_pend;

    assign wdec = decode_adr(bus.icb_wadr, NCH);
    assign rdec = decode_adr(bus.icb_radr, NCH);

    assign wr_psc   = bus.icb_wr && (wdec.sel == SEL_PSC);
    assign wr_inten = bus.icb_wr && (wdec.sel == SEL_INT_EN);
    assign wr_pend  = bus.icb_wr && (wdec.sel == SEL_INT_PEND);

    // Per-channel write strobes.
    always_comb begin
        we_ctrl  = '0;
        we_load  = '0;
        we_count = '0;
        for (int n = 0; n < NCH; n++) begin
            if (bus.icb_wr && (wdec.sel == SEL_CHAN) && (wdec.ch == 6'(n))) begin
                case (wdec.creg)
                    CH_CTRL:  we_ctrl[n]  = 1'b1;
                    CH_LOAD:  we_load[n]  = 1'b1;
                    CH_COUNT: we_count[n] = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    // Prescaler: tick when the counter matches PSC, giving one tick every
    // PSC+1 cycles; a PSC write restarts the count.
    assign tick = (pcnt_q == psc_q);

    always_comb begin
        psc_d  = psc_q;
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        if (wr_psc) begin
            psc_d  = bus.icb_wdat[PW-1:0];
            pcnt_d = '0;
        end
    end

    // Hardware set beats a software clear of the same bit.
    always_comb begin
        inten_d = wr_inten ? bus.icb_wdat[NCH-1:0] : inten_q;
        pend_d  = pend_q;
        if (wr_pend) begin
            pend_d = pend_q & ~bus.icb_wdat[NCH-1:0];
        end
        pend_d = pend_d | expire_vec;
    end

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        timer_bank_chan #(.CW(CW)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick),
            .we_ctrl_i  (we_ctrl[n]),
            .we_load_i  (we_load[n]),
            .we_count_i (we_count[n]),
            .wdat_i     (bus.icb_wdat),
            .en_o       (en_vec[n]),
            .periodic_o (per_vec[n]),
            .load_o     (load_arr[n]),
            .count_o    (count_arr[n]),
            .expire_o   (expire_vec[n])
        );
    end

    // Read mux; narrower registers are zero-extended by the default.
    always_comb begin
        rdat_mux = '0;
        case (rdec.sel)
            SEL_PSC:      rdat_mux[PW-1:0]  = psc_q;
            SEL_INT_EN:   rdat_mux[NCH-1:0] = inten_q;
            SEL_INT_PEND: rdat_mux[NCH-1:0] = pend_q;
            SEL_INFO:     rdat_mux          = INFO_VAL;
            SEL_CHAN: begin
                for (int n = 0; n < NCH; n++) begin
                    if (rdec.ch == 6'(n)) begin
                        case (rdec.creg)
                            CH_CTRL: begin
                                rdat_mux[CTRL_EN]       = en_vec[n];
                                rdat_mux[CTRL_PERIODIC] = per_vec[n];
                            end
                            CH_LOAD:  rdat_mux[CW-1:0] = load_arr[n];
                            CH_COUNT: rdat_mux[CW-1:0] = count_arr[n];
                            default:  ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q   <= '0;
            pcnt_q  <= '0;
            inten_q <= '0;
            pend_q  <= '0;
            wack_q  <= 1'b0;
            rack_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            psc_q   <= psc_d;
            pcnt_q  <= pcnt_d;
            inten_q <= inten_d;
            pend_q  <= pend_d;
            wack_q  <= bus.icb_wr;
            rack_q  <= bus.icb_rd;
            rdat_q  <= bus.icb_rd ? rdat_mux : '0;   // data only beside rack
        end
    end

    assign bus.icb_wack = wack_q;
    assign bus.icb_rack = rack_q;
    assign bus.icb_rdat = rdat_q;

    // Both operands are flops, so no ICB input reaches the interrupt pins.
    assign timer_int_vec = pend_q & inten_q;
    assign timer_int     = |timer_int_vec;

endmodule
